pipeline_hazard_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline; it sits beside the register forwarding logic and drives the write-enable and flush controls of PC, IF/ID, ID/EX and EX/MEM. It resolves load-use hazards, taken-branch flushes, multi-cycle MUL/DIV occupancy of EX, and external halt/resume. It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipeline_hazard_controller_pkg.sv | 20 ++
 rtl/load_use_detect.sv | 27 ++
 rtl/pipeline_hazard_controller.sv | 163 ++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
`default_nettype none
// =============================================================================
// Module   : pipeline_hazard_controller_pkg
// Brief    : State encodings and shared constants for the hazard controller.
// Revision : 1.0
// =============================================================================
package pipeline_hazard_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MD_BUSY  = 2'd1,
    ST_MD_DRAIN = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  localparam int c_MD_CYCLES_DEFAULT = 4;
  localparam int c_MD_CNT_W          = 4;

endpackage : pipeline_hazard_controller_pkg
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// =============================================================================
// Module   : load_use_detect
// Brief    : Flags a load in EX whose destination feeds a used source in ID.
// Revision : 1.0
// =============================================================================
module load_use_detect #(
  parameter int REG_W = 4
) (
  input  logic             i_ex_is_load,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic [REG_W-1:0] i_id_rs1,
  input  logic [REG_W-1:0] i_id_rs2,
  input  logic             i_id_uses_rs1,
  input  logic             i_id_uses_rs2,
  output logic             o_hazard
);

  logic w_hit_rs1;
  logic w_hit_rs2;

  assign w_hit_rs1 = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_hit_rs2 = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
  assign o_hazard  = i_ex_is_load && (w_hit_rs1 || w_hit_rs2);

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// =============================================================================
// Module   : pipeline_hazard_controller
// Brief    : Stall/flush sequencer for load-use, branch, MUL/DIV and halt.
// Revision : 1.0
// =============================================================================
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int REG_W     = 4,
  parameter int MD_CYCLES = c_MD_CYCLES_DEFAULT,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] i_id_rs1,
  input  logic [REG_W-1:0] i_id_rs2,
  input  logic             i_id_uses_rs1,
  input  logic             i_id_uses_rs2,
  input  logic             i_ex_is_load,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_is_muldiv,
  input  logic             i_branch_taken_ex,
  input  logic             i_halt_req,
  input  logic             i_resume,
  output logic             o_pc_write_en,
  output logic             o_ifid_write_en,
  output logic             o_idex_write_en,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic             o_exmem_flush,
  output logic             o_md_start,
  output logic             o_md_capture,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_stall_cycles
);

  localparam logic [c_MD_CNT_W-1:0] c_MD_LOAD = c_MD_CNT_W'(MD_CYCLES - 2);
  localparam logic [CNT_W-1:0]      c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [c_MD_CNT_W-1:0]   r_md_cnt;
  logic [c_MD_CNT_W-1:0]   w_md_cnt_nxt;
  logic                    r_halt_pending;
  logic                    w_halt_pending_nxt;
  logic [CNT_W-1:0]        r_stall_cycles;
  logic                    w_load_use;
  logic                    w_stall_inc;

  load_use_detect #(
    .REG_W (REG_W)
  ) u_load_use_detect (
    .i_ex_is_load  (i_ex_is_load),
    .i_ex_rd       (i_ex_rd),
    .i_id_rs1      (i_id_rs1),
    .i_id_rs2      (i_id_rs2),
    .i_id_uses_rs1 (i_id_uses_rs1),
    .i_id_uses_rs2 (i_id_uses_rs2),
    .o_hazard      (w_load_use)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_md_cnt       <= '0;
      r_halt_pending <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_md_cnt       <= w_md_cnt_nxt;
      r_halt_pending <= w_halt_pending_nxt;
      if (w_stall_inc && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + c_CNT_ONE;
      end
    end
  end

  // RUN events are mutually exclusive: only the highest-priority one acts.
  always_comb begin
    w_state_nxt        = r_state;
    w_md_cnt_nxt       = r_md_cnt;
    w_halt_pending_nxt = r_halt_pending;
    o_pc_write_en      = 1'b1;
    o_ifid_write_en    = 1'b1;
    o_idex_write_en    = 1'b1;
    o_ifid_flush       = 1'b0;
    o_idex_flush       = 1'b0;
    o_exmem_flush      = 1'b0;
    o_md_start         = 1'b0;
    o_md_capture       = 1'b0;
    o_halted           = 1'b0;

    if (rst) begin
      o_pc_write_en   = 1'b0;
      o_ifid_write_en = 1'b0;
      o_idex_write_en = 1'b0;
      o_ifid_flush    = 1'b1;
      o_idex_flush    = 1'b1;
      o_exmem_flush   = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (i_branch_taken_ex) begin
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
          end else if (i_ex_is_muldiv) begin
            o_md_start      = 1'b1;
            o_pc_write_en   = 1'b0;
            o_ifid_write_en = 1'b0;
            o_idex_write_en = 1'b0;
            o_exmem_flush   = 1'b1;
            w_md_cnt_nxt    = c_MD_LOAD;
            w_state_nxt     = ST_MD_BUSY;
          end else if (w_load_use) begin
            o_pc_write_en   = 1'b0;
            o_ifid_write_en = 1'b0;
            o_idex_flush    = 1'b1;
          end else if (i_halt_req) begin
            w_state_nxt = ST_HALT;
          end
        end
        ST_MD_BUSY: begin
          o_pc_write_en   = 1'b0;
          o_ifid_write_en = 1'b0;
          o_idex_write_en = 1'b0;
          o_exmem_flush   = 1'b1;
          if (i_halt_req) begin
            w_halt_pending_nxt = 1'b1;
          end
          if (r_md_cnt == '0) begin
            w_state_nxt = ST_MD_DRAIN;
          end else begin
            w_md_cnt_nxt = r_md_cnt - c_MD_CNT_W'(1);
          end
        end
        ST_MD_DRAIN: begin
          o_md_capture       = 1'b1;
          w_halt_pending_nxt = 1'b0;
          w_state_nxt        = (r_halt_pending || i_halt_req) ? ST_HALT : ST_RUN;
        end
        ST_HALT: begin
          o_pc_write_en   = 1'b0;
          o_ifid_write_en = 1'b0;
          o_idex_write_en = 1'b0;
          o_halted        = 1'b1;
          if (i_resume) begin
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  // HALT is a deliberate freeze, not a hazard, so it is kept out of the count.
  assign w_stall_inc    = !o_pc_write_en && (r_state != ST_HALT);
  assign o_stall_cycles = r_stall_cycles;

endmodule : pipeline_hazard_controller
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// =============================================================================
// Module   : tb_pipeline_hazard_controller
// Brief    : Vector-table bench with an expected-output queue for the controller.
// Revision : 1.0
// =============================================================================
module tb_pipeline_hazard_controller;

  localparam int REG_W     = 4;
  localparam int MD_CYCLES = 4;
  localparam int CNT_W     = 16;

  typedef struct packed {
    logic rst;
    logic [REG_W-1:0] rs1;
    logic u1;
    logic [REG_W-1:0] rs2;
    logic u2;
    logic ld;
    logic [REG_W-1:0] rd;
    logic md;
    logic br;
    logic hr;
    logic res;
  } ins_t;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic f_ifid;
    logic f_idex;
    logic f_exmem;
    logic mds;
    logic mdc;
    logic hlt;
    logic [CNT_W-1:0] cnt;
  } outs_t;

  typedef struct {
    string name;
    ins_t  i;
    outs_t o;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic             id_uses_rs1, id_uses_rs2, ex_is_load, ex_is_muldiv;
  logic             branch_taken_ex, halt_req, resume;
  logic             pc_we, ifid_we, idex_we, ifid_fl, idex_fl, exmem_fl;
  logic             md_start, md_capture, halted;
  logic [CNT_W-1:0] stall_cycles;

  int    checks = 0;
  int    errors = 0;
  vec_t  tbl[$];
  outs_t sb[$];

  always #5 clk = ~clk;

  pipeline_hazard_controller #(
    .REG_W     (REG_W),
    .MD_CYCLES (MD_CYCLES),
    .CNT_W     (CNT_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_id_rs1          (id_rs1),
    .i_id_rs2          (id_rs2),
    .i_id_uses_rs1     (id_uses_rs1),
    .i_id_uses_rs2     (id_uses_rs2),
    .i_ex_is_load      (ex_is_load),
    .i_ex_rd           (ex_rd),
    .i_ex_is_muldiv    (ex_is_muldiv),
    .i_branch_taken_ex (branch_taken_ex),
    .i_halt_req        (halt_req),
    .i_resume          (resume),
    .o_pc_write_en     (pc_we),
    .o_ifid_write_en   (ifid_we),
    .o_idex_write_en   (idex_we),
    .o_ifid_flush      (ifid_fl),
    .o_idex_flush      (idex_fl),
    .o_exmem_flush     (exmem_fl),
    .o_md_start        (md_start),
    .o_md_capture      (md_capture),
    .o_halted          (halted),
    .o_stall_cycles    (stall_cycles)
  );

  function automatic ins_t mk_in(logic r, logic l, logic [REG_W-1:0] d,
                                 logic [REG_W-1:0] s1, logic us1,
                                 logic [REG_W-1:0] s2, logic us2,
                                 logic m, logic b, logic h, logic rs);
    ins_t v;
    v.rst = r;  v.ld = l;  v.rd = d;
    v.rs1 = s1; v.u1 = us1; v.rs2 = s2; v.u2 = us2;
    v.md = m;   v.br = b;  v.hr = h;  v.res = rs;
    return v;
  endfunction

  function automatic outs_t mk_out(logic [8:0] bits, int c);
    outs_t v;
    {v.pc, v.ifid, v.idex, v.f_ifid, v.f_idex, v.f_exmem, v.mds, v.mdc, v.hlt} = bits;
    v.cnt = CNT_W'(c);
    return v;
  endfunction

  // bit order: pc ifid idex | f_ifid f_idex f_exmem | md_start md_capture halted
  localparam logic [8:0] O_DEF   = 9'b111_000_000;
  localparam logic [8:0] O_RST   = 9'b000_111_000;
  localparam logic [8:0] O_LU    = 9'b001_010_000;
  localparam logic [8:0] O_BR    = 9'b111_110_000;
  localparam logic [8:0] O_MDS   = 9'b000_001_100;
  localparam logic [8:0] O_BUSY  = 9'b000_001_000;
  localparam logic [8:0] O_DRAIN = 9'b111_000_010;
  localparam logic [8:0] O_HALT  = 9'b000_000_001;

  function automatic outs_t actual();
    outs_t v;
    {v.pc, v.ifid, v.idex, v.f_ifid, v.f_idex, v.f_exmem, v.mds, v.mdc, v.hlt} =
      {pc_we, ifid_we, idex_we, ifid_fl, idex_fl, exmem_fl, md_start, md_capture, halted};
    v.cnt = stall_cycles;
    return v;
  endfunction

  task automatic add(string n, ins_t i, logic [8:0] b, int c);
    vec_t v;
    v.name = n; v.i = i; v.o = mk_out(b, c);
    tbl.push_back(v);
  endtask

  task automatic drive(ins_t i);
    rst = i.rst; ex_is_load = i.ld; ex_rd = i.rd;
    id_rs1 = i.rs1; id_uses_rs1 = i.u1; id_rs2 = i.rs2; id_uses_rs2 = i.u2;
    ex_is_muldiv = i.md; branch_taken_ex = i.br; halt_req = i.hr; resume = i.res;
  endtask

  task automatic check(string name);
    outs_t e, a;
    checks++;
    a = actual();
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: no expected entry queued, got %h", name, a);
    end else begin
      e = sb.pop_front();
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %h required %h", name, a, e);
      end
    end
  endtask

  initial begin
    ins_t idle, rsti;
    idle = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rsti = mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    add("reset",        rsti, O_RST, 0);
    add("idle0",        idle, O_DEF, 0);
    add("lu_rs2",       mk_in(0, 1, 5, 0, 0, 5, 1, 0, 0, 0, 0), O_LU, 0);
    add("lu_release",   idle, O_DEF, 1);
    add("unused_src",   mk_in(0, 1, 5, 5, 0, 5, 0, 0, 0, 0, 0), O_DEF, 1);
    add("rd_mismatch",  mk_in(0, 1, 6, 5, 1, 5, 1, 0, 0, 0, 0), O_DEF, 1);
    add("lu_rs1",       mk_in(0, 1, 3, 3, 1, 0, 0, 0, 0, 0, 0), O_LU, 1);
    add("idle1",        idle, O_DEF, 2);
    add("br_over_lu",   mk_in(0, 1, 3, 3, 1, 0, 0, 0, 1, 0, 0), O_BR, 2);
    add("after_br",     idle, O_DEF, 2);
    add("no_load",      mk_in(0, 0, 3, 3, 1, 0, 0, 0, 0, 0, 0), O_DEF, 2);
    add("md_entry",     mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), O_MDS, 2);
    add("md_busy1",     mk_in(0, 1, 3, 3, 1, 0, 0, 1, 1, 0, 0), O_BUSY, 3);
    add("md_busy2",     mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), O_BUSY, 4);
    add("md_busy3",     mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), O_BUSY, 5);
    add("md_drain",     mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), O_DRAIN, 6);
    add("md_back_run",  idle, O_DEF, 6);
    add("md2_entry",    mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), O_MDS, 6);
    add("md2_busy1",    idle, O_BUSY, 7);
    add("md2_busy2_hr", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), O_BUSY, 8);
    add("md2_busy3",    idle, O_BUSY, 9);
    add("md2_drain",    idle, O_DRAIN, 10);
    add("halt_pend",    idle, O_HALT, 10);
    add("halt_frozen",  mk_in(0, 1, 5, 0, 0, 5, 1, 1, 1, 1, 0), O_HALT, 10);
    add("halt_resume",  mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), O_HALT, 10);
    add("resumed",      idle, O_DEF, 10);
    add("halt_req_run", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), O_DEF, 10);
    add("halt_direct",  idle, O_HALT, 10);
    add("resume2",      mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), O_HALT, 10);
    add("run2",         idle, O_DEF, 10);
    add("md3_entry",    mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), O_MDS, 10);
    add("md3_busy1",    idle, O_BUSY, 11);
    add("rst_in_busy",  rsti, O_RST, 12);
    add("post_rst",     idle, O_DEF, 0);
    add("post_rst2",    idle, O_DEF, 0);

    drive(rsti);
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[k]) begin
      drive(tbl[k].i);
      sb.push_back(tbl[k].o);
      #2;
      check(tbl[k].name);
      @(posedge clk);
      #1;
    end

    // Continuous load-use drives the counter to saturation.
    drive(mk_in(0, 1, 7, 7, 1, 0, 0, 0, 0, 0, 0));
    repeat (65534) @(posedge clk);
    #1;
    sb.push_back(mk_out(O_LU, 65534));
    check("sat_fffe");
    repeat (1) @(posedge clk);
    #1;
    sb.push_back(mk_out(O_LU, 65535));
    check("sat_ffff");
    repeat (5) @(posedge clk);
    #1;
    sb.push_back(mk_out(O_LU, 65535));
    check("sat_hold");
    drive(idle);
    @(posedge clk);
    #1;
    sb.push_back(mk_out(O_DEF, 65535));
    check("sat_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pipeline_hazard_controller
`default_nettype wire
